// File: rtl/lcd_arb_pkg.sv
// Shared types and constants for the LCD write-port arbiter.
package lcd_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      STROBE_LO,
      STROBE_HI,
      RELEASE
   } lcd_arb_state_t;

   localparam int NUM_REQ = 2;
   localparam int STALL_W = 8;
   localparam int TMR_W   = 8;

   // One-hot grant vector for a requester index
   function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
      return NUM_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/lcd_wr_timer.sv
// Loadable down-counter timing the WRX low and high phases.
// done is high while the count is zero, i.e. in the final cycle of a phase.
module lcd_wr_timer
   import lcd_arb_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   output logic             done
);

   logic [TMR_W-1:0] cnt;

   // Load a phase length minus one, then count down and hold at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Two-requester arbiter for the shared 8080-style LCD write port.
// Grants whole bursts, sequences CSX/DCX/WRX and releases the bus on burst
// end, stall timeout or disable.
// Build option: LCD_ARB_ROUND_ROBIN_EN selects round-robin on simultaneous
// requests; otherwise requester 0 has fixed priority.
module lcd_bus_arbiter
   import lcd_arb_pkg::*;
#(
   parameter int WR_LOW_CYCLES  = 2,
   parameter int WR_HIGH_CYCLES = 2,
   parameter int IDLE_TIMEOUT   = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] valid,
   input  logic [NUM_REQ-1:0] dc,
   input  logic [NUM_REQ-1:0] last,
   input  logic [7:0]         data0,
   input  logic [7:0]         data1,
   output logic [NUM_REQ-1:0] ready,
   output logic [NUM_REQ-1:0] grant,
   output logic               busy,
   output logic               timeout,
   output logic               lcd_csx,
   output logic               lcd_wrx,
   output logic               lcd_dcx,
   output logic [7:0]         lcd_d
);

   localparam logic [TMR_W-1:0]   LO_LOAD   = TMR_W'(WR_LOW_CYCLES - 1);
   localparam logic [TMR_W-1:0]   HI_LOAD   = TMR_W'(WR_HIGH_CYCLES - 1);
   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(IDLE_TIMEOUT - 1);

   lcd_arb_state_t     state;
   logic               gidx;
   logic               sel_idx;
   logic               last_q;
   logic [STALL_W-1:0] stall_cnt;
   logic               tmr_load;
   logic [TMR_W-1:0]   tmr_val;
   logic               tmr_done;

`ifdef LCD_ARB_ROUND_ROBIN_EN
   logic rr_ptr;

   // Favoured requester wins a tie; a lone request always wins
   always_comb begin
      sel_idx = (req[0] && req[1]) ? rr_ptr : req[1];
   end

   // After each release, favour the requester that did not just own the bus
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= 1'b0;
      end else if (state == RELEASE) begin
         rr_ptr <= ~gidx;
      end
   end
`else
   // Fixed priority: requester 0 whenever it asks
   always_comb begin
      sel_idx = ~req[0];
   end
`endif

   // Only the owner sees ready, and only while the FSM waits for a byte
   always_comb begin
      ready = '0;
      if (state == GRANT) begin
         ready[gidx] = valid[gidx];
      end
   end

   // Strobe timer is loaded on the handshake and at the low-to-high switch
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = LO_LOAD;
      if (state == GRANT && valid[gidx]) begin
         tmr_load = 1'b1;
      end else if (state == STROBE_LO && tmr_done) begin
         tmr_load = 1'b1;
         tmr_val  = HI_LOAD;
      end
   end

   lcd_wr_timer u_wr_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // Main sequencer; a byte in flight always finishes its strobe before release
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         gidx      <= 1'b0;
         grant     <= '0;
         busy      <= 1'b0;
         timeout   <= 1'b0;
         lcd_csx   <= 1'b1;
         lcd_wrx   <= 1'b1;
         lcd_dcx   <= 1'b1;
         lcd_d     <= '0;
         last_q    <= 1'b0;
         stall_cnt <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (en && |req) begin
                  gidx      <= sel_idx;
                  grant     <= req_onehot(sel_idx);
                  lcd_csx   <= 1'b0;
                  busy      <= 1'b1;
                  stall_cnt <= '0;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (valid[gidx]) begin
                  lcd_d     <= gidx ? data1 : data0;
                  lcd_dcx   <= dc[gidx];
                  last_q    <= last[gidx];
                  stall_cnt <= '0;
                  lcd_wrx   <= 1'b0;
                  state     <= STROBE_LO;
               end else if (!req[gidx] || !en) begin
                  lcd_csx <= 1'b1;
                  grant   <= '0;
                  state   <= RELEASE;
               end else if (stall_cnt == STALL_MAX) begin
                  timeout <= 1'b1;
                  lcd_csx <= 1'b1;
                  grant   <= '0;
                  state   <= RELEASE;
               end else begin
                  stall_cnt <= stall_cnt + 1'b1;
               end
            end
            STROBE_LO: begin
               if (tmr_done) begin
                  lcd_wrx <= 1'b1;
                  state   <= STROBE_HI;
               end
            end
            STROBE_HI: begin
               if (tmr_done) begin
                  if (last_q || !en) begin
                     lcd_csx <= 1'b1;
                     grant   <= '0;
                     state   <= RELEASE;
                  end else begin
                     state <= GRANT;
                  end
               end
            end
            RELEASE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/lcd_bus_arbiter.md
# lcd_bus_arbiter

Shares the single 8080-style parallel LCD write port between two on-chip requesters: requester 0 is the scene renderer, requester 1 is the score/overlay renderer. It sits between the game engine and the GPIO output mux inside the team project, and runs only while the project enable is high. It grants whole bursts, sequences CSX/DCX/WRX with parameterised strobe widths, and releases the bus on burst end, stall timeout or disable.

## Interface
- WR_LOW_CYCLES, 2, cycles WRX held low per byte (≥1)
- WR_HIGH_CYCLES, 2, cycles WRX held high after each byte (≥1)
- IDLE_TIMEOUT, 255, consecutive GRANT cycles without valid before forced release (≥1, 8-bit counter)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  project enable; low blocks new grants
- req  in  2  per-requester bus request, level
- valid  in  2  per-requester byte available
- dc  in  2  per-requester data(1)/command(0) flag for the offered byte
- last  in  2  per-requester final-byte-of-burst flag
- data0, data1  in  8 each  offered byte
- ready  out  2  combinational accept; a byte transfers on a rising edge with valid[g] & ready[g]
- grant  out  2  one-hot registered grant, 0 when idle
- busy  out  1  high in any state other than IDLE
- timeout  out  1  one-cycle pulse on forced release
- lcd_csx, lcd_wrx, lcd_dcx  out  1 each  LCD strobes, active-low CSX/WRX
- lcd_d  out  8  LCD data bus

## Operation
- Reset values: grant=0, ready=0, busy=0, timeout=0, lcd_csx=1, lcd_wrx=1, lcd_dcx=1, lcd_d=0x00; state IDLE; RR pointer favours requester 0.
- IDLE: if en & |req, register grant to the selected requester, go to GRANT, drive lcd_csx=0.
- GRANT: ready[g]=valid[g]; nothing else is asserted on ready. On handshake: latch data/dc into lcd_d/lcd_dcx, latch last, clear the stall counter, go to STROBE_LO. With no valid: increment the stall counter. On reaching IDLE_TIMEOUT, pulse timeout and go to RELEASE. If req[g]=0 or en=0, go to RELEASE.
- STROBE_LO: lcd_wrx=0 for WR_LOW_CYCLES, then go to STROBE_HI.
- STROBE_HI: lcd_wrx=1 for WR_HIGH_CYCLES. Then go to RELEASE if the latched last was set or en=0; otherwise go to GRANT.
- RELEASE: one cycle with lcd_csx=1 and grant=0; update RR pointer to favour the other requester; go to IDLE.
- lcd_d and lcd_dcx hold their values from the latch point until the next handshake.
- Dropping req or en mid-byte never truncates the strobe; the current byte always completes.

## Timing
- Request seen in IDLE at cycle N: grant and lcd_csx=0 at N+1; the earliest handshake is at the end of cycle N+1.
- Handshake at the end of cycle M: lcd_wrx low in cycles M+1…M+WR_LOW_CYCLES; next GRANT at M+WR_LOW_CYCLES+WR_HIGH_CYCLES+1.
- Sustained throughput: one byte per WR_LOW_CYCLES+WR_HIGH_CYCLES+1 cycles.
- Minimum gap between bursts: RELEASE + IDLE, i.e. CSX high for at least 2 cycles.
- Simultaneous req in IDLE: resolved by the arbitration policy (see Configuration).
- A request arriving during RELEASE is considered in IDLE on the next cycle.
- rst asserted at any point forces all outputs to reset values immediately, without waiting for a clock edge; an in-flight byte is discarded.

## Configuration
- LCD_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, the requester not granted most recently wins.
- Not defined: fixed priority, requester 0 always wins, and the RR pointer logic is removed.

## Structure
- Package lcd_arb_pkg:
  - state enum (IDLE, GRANT, STROBE_LO, STROBE_HI, RELEASE)
  - NUM_REQ=2
  - STALL_W=8
- Sub-module lcd_wr_timer: loadable down-counter producing `done` for the STROBE_LO and STROBE_HI phases.

## Test plan
- Single burst, defaults: req0 with 3 valid bytes 0x2A(cmd), 0x01, 0x02(last). Expect:
  - grant=01 one cycle after req;
  - handshakes 5 cycles apart;
  - 3 WRX low pulses of 2 cycles each;
  - CSX high in RELEASE exactly 5 cycles after the last handshake.
- Contention: req0 and req1 both raised in the same cycle, each with a 1-byte burst.
  - With LCD_ARB_ROUND_ROBIN_EN: grant order 01, 10, then 01 on a repeat.
  - Without the macro: 01 first on every repeat.
- Stall: req1 granted with valid held 0. Expect timeout pulse, then release, 255 cycles after grant; lcd_wrx never toggles.
- Disable mid-burst: en dropped during STROBE_LO of byte 2 of 4. Expect byte 2 strobe to complete, then RELEASE, and no new grant while en=0.
- Async reset mid-strobe: rst raised while lcd_wrx=0. Expect lcd_wrx=1, lcd_csx=1, grant=0 before the next clk edge.
- Parameter sweep WR_LOW_CYCLES=1, WR_HIGH_CYCLES=3: expect a 1-cycle WRX low pulse and 5-cycle byte spacing.
